// File: rtl/time_of_day_counter.sv
// Time-of-day clock: prescaled one-second advance of a 24-hour BCD time,
// with binary load, range-checked load errors and a 12/24-hour hour display.
module time_of_day_counter #(
    parameter int unsigned DIV_COUNT = 100000000,
    parameter int unsigned DIV_W     = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [4:0] load_hrs,
    input  logic [5:0] load_mins,
    input  logic [5:0] load_secs,
    output logic [3:0] sec_units,
    output logic [2:0] sec_tens,
    output logic [3:0] min_units,
    output logic [2:0] min_tens,
    output logic [3:0] hour_units,
    output logic [1:0] hour_tens,
    output logic       pm,
    output logic       tick,
    output logic       day_wrap,
    output logic       load_err
);

    localparam logic [DIV_W-1:0] PRESC_TERM = DIV_W'(DIV_COUNT - 1);
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] presc;
    logic [3:0]       sec_u, min_u, hr_u;
    logic [2:0]       sec_t, min_t;
    logic [1:0]       hr_t;

    logic [3:0]       nxt_sec_u, nxt_min_u, nxt_hr_u;
    logic [2:0]       nxt_sec_t, nxt_min_t;
    logic [1:0]       nxt_hr_t;
    logic             day_end;

    logic             presc_last;
    logic             advance;
    logic             load_ok;

    logic [4:0]       hour_bin;
    logic [4:0]       hour_disp;

    assign presc_last = (presc == PRESC_TERM);
    assign advance    = enable && !load && presc_last;
    assign load_ok    = (load_hrs <= 5'd23) && (load_mins <= 6'd59) && (load_secs <= 6'd59);

    // One-second increment with full ripple; 23:59:59 goes straight to 00:00:00.
    always_comb begin
        nxt_sec_u = sec_u;
        nxt_sec_t = sec_t;
        nxt_min_u = min_u;
        nxt_min_t = min_t;
        nxt_hr_u  = hr_u;
        nxt_hr_t  = hr_t;
        day_end   = 1'b0;
        if (sec_u != 4'd9) begin
            nxt_sec_u = sec_u + 4'd1;
        end else begin
            nxt_sec_u = 4'd0;
            if (sec_t != 3'd5) begin
                nxt_sec_t = sec_t + 3'd1;
            end else begin
                nxt_sec_t = 3'd0;
                if (min_u != 4'd9) begin
                    nxt_min_u = min_u + 4'd1;
                end else begin
                    nxt_min_u = 4'd0;
                    if (min_t != 3'd5) begin
                        nxt_min_t = min_t + 3'd1;
                    end else begin
                        nxt_min_t = 3'd0;
                        if (hr_t == 2'd2 && hr_u == 4'd3) begin
                            nxt_hr_t = 2'd0;
                            nxt_hr_u = 4'd0;
                            day_end  = 1'b1;
                        end else if (hr_u == 4'd9) begin
                            nxt_hr_u = 4'd0;
                            nxt_hr_t = hr_t + 2'd1;
                        end else begin
                            nxt_hr_u = hr_u + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            sec_u    <= '0;
            sec_t    <= '0;
            min_u    <= '0;
            min_t    <= '0;
            hr_u     <= '0;
            hr_t     <= '0;
            tick     <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
            // A load, good or bad, always pre-empts the advance on this edge.
            if (load) begin
                if (load_ok) begin
                    presc <= '0;
                    sec_u <= 4'(load_secs % 6'd10);
                    sec_t <= 3'(load_secs / 6'd10);
                    min_u <= 4'(load_mins % 6'd10);
                    min_t <= 3'(load_mins / 6'd10);
                    hr_u  <= 4'(load_hrs % 5'd10);
                    hr_t  <= 2'(load_hrs / 5'd10);
                end else begin
                    load_err <= 1'b1;
                end
            end else if (enable) begin
                presc <= presc_last ? '0 : presc + PRESC_ONE;
                if (advance) begin
                    sec_u    <= nxt_sec_u;
                    sec_t    <= nxt_sec_t;
                    min_u    <= nxt_min_u;
                    min_t    <= nxt_min_t;
                    hr_u     <= nxt_hr_u;
                    hr_t     <= nxt_hr_t;
                    tick     <= 1'b1;
                    day_wrap <= day_end;
                end
            end
        end
    end

    assign hour_bin = 5'(hr_t) * 5'd10 + 5'(hr_u);
    assign pm       = (hour_bin >= 5'd12);

    always_comb begin
        hour_disp = hour_bin;
        if (mode_12h) begin
            if (hour_bin == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour_bin > 5'd12) begin
                hour_disp = hour_bin - 5'd12;
            end
        end
    end

    assign sec_units  = sec_u;
    assign sec_tens   = sec_t;
    assign min_units  = min_u;
    assign min_tens   = min_t;
    assign hour_units = 4'(hour_disp % 5'd10);
    assign hour_tens  = 2'(hour_disp / 5'd10);

endmodule
